max_min_job_ctrl: RTL and testbench
===================================

// Module: max_min_job_ctrl
// PURPOSE
// Host-side initiator for accelerator_max_min. Accepts a job (base address, word count),
// reads packed 4x8-bit words from a 1-cycle-latency memory and feeds them to the accelerator
// one start/done transaction at a time. Returns the final running max/min to the host over a
// valid/ready result channel. Sits between the NDP command path and the accelerator.
// PARAMETERS
// ADDR_W          16     memory word-address width
// CNT_W           16     job word-count width
// TIMEOUT_CYCLES  1024   done watchdog limit (used only with MAX_MIN_TIMEOUT_EN)
// PORTS
// clk_i         in   1        clock, all logic rising-edge
// arst_i        in   1        asynchronous reset, active-low
// cmd_valid_i   in   1        job request valid
// cmd_ready_o   out  1        high only in IDLE
// cmd_base_i    in   ADDR_W   first word address
// cmd_count_i   in   CNT_W    number of 32-bit words
// mem_rd_en_o   out  1        read strobe; mem_rdata_i valid the next cycle
// mem_addr_o    out  ADDR_W   read address
// mem_rdata_i   in   32       read data
// acc_clr_o     out  1        1-cycle pulse clearing accelerator running max/min
// acc_start_o   out  1        1-cycle start pulse to accelerator
// acc_data_o    out  32       accelerator data_in; stable from start until done seen
// acc_done_i    in   1        accelerator done
// acc_result_i  in   32       accelerator data_out ([15:8]=max, [7:0]=min)
// res_valid_o   out  1        result valid, held until res_ready_i
// res_ready_i   in   1        host accepts result
// res_max_o     out  8        final max
// res_min_o     out  8        final min
// res_err_o     out  1        job aborted by watchdog (0 when macro absent)
// BEHAVIOUR
// - Reset (arst_i=0): state IDLE; all outputs 0 except cmd_ready_o=1; internal counters 0.
// - FSM: IDLE -> CLEAR -> READ -> DATA -> START -> WAIT_DONE -> CAPTURE -> (READ | RESULT) -> IDLE.
// - IDLE: cmd_valid_i & cmd_ready_o latches base/count. count==0 -> RESULT directly with
//   max=0x00, min=0xFF, no memory or accelerator activity. Else -> CLEAR.
// - CLEAR: acc_clr_o=1 one cycle; addr<=base, remaining<=count.
// - READ: mem_rd_en_o=1, mem_addr_o=addr, one cycle. DATA: register mem_rdata_i into acc_data_o.
// - START: acc_start_o=1 exactly one cycle, never re-asserted before done is seen.
// - WAIT_DONE: hold until acc_done_i=1. CAPTURE (next cycle): latch acc_result_i[15:8]/[7:0],
//   addr+1 (wraps modulo 2^ADDR_W), remaining-1; remaining reaches 0 -> RESULT else READ.
// - Per-word latency READ..CAPTURE = 5 cycles + accelerator done latency.
// - RESULT: res_valid_o=1 with stable max/min/err until res_ready_i=1; transfer cycle -> IDLE.
//   res_ready_i high before valid has no effect. cmd_valid_i ignored outside IDLE.
// - acc_done_i outside WAIT_DONE is ignored. Full-range count (2^CNT_W-1) must complete.
// - Reset mid-job: immediate return to IDLE, no result emitted; host must resubmit.
// CONFIGURATION
// MAX_MIN_TIMEOUT_EN defined: watchdog counts cycles in WAIT_DONE; reaching TIMEOUT_CYCLES
//   aborts job -> RESULT with res_err_o=1, max/min = last captured values; counter clears on
//   each START.
// MAX_MIN_TIMEOUT_EN undefined: no counter, WAIT_DONE waits indefinitely, res_err_o tied 0.
// TESTING
// 1 Job base=0,count=3, mem={0x01020304,0x05060708,0x090A0B0C} -> 3 starts, res max=0x0C min=0x01 err=0.
// 2 count=0 -> res_valid_o 2 cycles after accept, max=0x00 min=0xFF, no mem_rd_en_o/acc_start_o.
// 3 Job count=2 words 0xFFFFFFFF,0x00000000, res_ready_i low 10 cycles -> outputs stable, then
//   max=0xFF min=0x00, cmd_ready_o only after transfer.
// 4 arst_i low during WAIT_DONE of word 2 of 4 -> all outputs reset values; new job count=1
//   word 0x05060708 -> max=0x08 min=0x05.
// 5 base=0xFFFF,count=2 -> reads addr 0xFFFF then 0x0000; acc_start_o exactly 1 cycle per word.
// 6 MAX_MIN_TIMEOUT_EN, acc_done_i stuck 0 -> res_err_o=1 after 1024 cycles in WAIT_DONE.

Source files
------------

// File: rtl/max_min_job_ctrl.sv
// Job controller that streams packed 4x8-bit words from memory through accelerator_max_min
// and returns the final max/min; define MAX_MIN_TIMEOUT_EN to add the done watchdog.
module max_min_job_ctrl #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [CNT_W-1:0]  cmd_count_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              acc_clr_o,
  output logic              acc_start_o,
  output logic [31:0]       acc_data_o,
  input  logic              acc_done_i,
  input  logic [31:0]       acc_result_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [7:0]        res_max_o,
  output logic [7:0]        res_min_o,
  output logic              res_err_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_READ    = 3'd2,
    S_DATA    = 3'd3,
    S_START   = 3'd4,
    S_WAIT    = 3'd5,
    S_CAPTURE = 3'd6,
    S_RESULT  = 3'd7
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [31:0]       data_q, data_d;
  logic [7:0]        max_q, max_d;
  logic [7:0]        min_q, min_d;
  logic              cmd_ready_q, rd_en_q, clr_q, start_q, valid_q;

`ifdef MAX_MIN_TIMEOUT_EN
  localparam int unsigned     WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_ONE   = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 32'd1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // Only the max/min byte lanes of the accelerator result carry information.
  logic unused_s;
  assign unused_s = ^{acc_result_i[31:16], TIMEOUT_CYCLES[0]};

  // State register.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update decisions.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    max_d   = max_q;
    min_d   = min_q;
`ifdef MAX_MIN_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          base_d = cmd_base_i;
          cnt_d  = cmd_count_i;
`ifdef MAX_MIN_TIMEOUT_EN
          err_d  = 1'b0;
`endif
          if (cmd_count_i == '0) begin
            max_d   = 8'h00;
            min_d   = 8'hFF;
            state_d = S_RESULT;
          end else begin
            state_d = S_CLEAR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        addr_d  = base_q;
        rem_d   = cnt_q;
        max_d   = 8'h00;
        min_d   = 8'hFF;
        state_d = S_READ;
      end
      S_READ: begin
        state_d = S_DATA;
      end
      S_DATA: begin
        data_d  = mem_rdata_i;
        state_d = S_START;
      end
      S_START: begin
`ifdef MAX_MIN_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (acc_done_i) begin
          state_d = S_CAPTURE;
        end else begin
`ifdef MAX_MIN_TIMEOUT_EN
          if (wd_q == WD_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_RESULT;
          end else begin
            wd_d = wd_q + WD_ONE;
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_CAPTURE: begin
        max_d  = acc_result_i[15:8];
        min_d  = acc_result_i[7:0];
        addr_d = addr_q + ADDR_ONE;
        rem_d  = rem_q - CNT_ONE;
        if (rem_q == CNT_ONE) begin
          state_d = S_RESULT;
        end else begin
          state_d = S_READ;
        end
      end
      S_RESULT: begin
        if (res_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESULT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      base_q <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
      rem_q  <= '0;
      data_q <= 32'h0000_0000;
      max_q  <= 8'h00;
      min_q  <= 8'h00;
    end else begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      rem_q  <= rem_d;
      data_q <= data_d;
      max_q  <= max_d;
      min_q  <= min_d;
    end
  end

  // Strobes are decoded from the next state so they are glitch-free flops.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      cmd_ready_q <= 1'b1;
      rd_en_q     <= 1'b0;
      clr_q       <= 1'b0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      cmd_ready_q <= (state_d == S_IDLE);
      rd_en_q     <= (state_d == S_READ);
      clr_q       <= (state_d == S_CLEAR);
      start_q     <= (state_d == S_START);
      valid_q     <= (state_d == S_RESULT);
    end
  end

`ifdef MAX_MIN_TIMEOUT_EN
  // Watchdog counter and abort flag.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign res_err_o = err_q;
`else
  assign res_err_o = 1'b0;
`endif

  assign cmd_ready_o = cmd_ready_q;
  assign mem_rd_en_o = rd_en_q;
  assign mem_addr_o  = addr_q;
  assign acc_clr_o   = clr_q;
  assign acc_start_o = start_q;
  assign acc_data_o  = data_q;
  assign res_valid_o = valid_q;
  assign res_max_o   = max_q;
  assign res_min_o   = min_q;

endmodule

// File: tb/tb_max_min_job_ctrl.sv
// Self-checking bench for max_min_job_ctrl: memory and accelerator models, table of jobs,
// result scoreboard, plus reset-mid-job and (with MAX_MIN_TIMEOUT_EN) watchdog sequences.
module tb_max_min_job_ctrl;

  typedef struct packed {
    logic [15:0]      base;
    logic [15:0]      count;
    logic [3:0][31:0] w;
    logic [7:0]       lat;
    logic [7:0]       hold;
    logic             early;
    logic [7:0]       emax;
    logic [7:0]       emin;
  } vec_t;

  typedef struct packed {
    logic [7:0] mx;
    logic [7:0] mn;
    logic       err;
  } exp_t;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_base, cmd_count;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        acc_clr, acc_start, acc_done;
  logic [31:0] acc_data, acc_result;
  logic        res_valid, res_ready, res_err;
  logic [7:0]  res_max, res_min;

  logic [31:0] mem [0:65535];
  logic [7:0]  amax, amin;
  logic [31:0] pend;
  logic        busy;
  int          dly;
  int          lat_cfg;
  bit          stuck;

  int          n_tests = 0;
  int          n_fail = 0;
  int          rd_total = 0;
  int          start_total = 0;
  int          start_wide = 0;
  int          data_viol = 0;
  int          restart_viol = 0;
  logic        prev_start = 1'b0;
  logic [15:0] addr_log [$];
  exp_t        sb [$];
  vec_t        vecs [7];

  max_min_job_ctrl dut (
    .clk_i(clk), .arst_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_base_i(cmd_base), .cmd_count_i(cmd_count),
    .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
    .acc_clr_o(acc_clr), .acc_start_o(acc_start), .acc_data_o(acc_data),
    .acc_done_i(acc_done), .acc_result_i(acc_result),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_max_o(res_max), .res_min_o(res_min), .res_err_o(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bmax(input logic [31:0] w, input logic [7:0] cur);
    logic [7:0] m;
    m = cur;
    for (int b = 0; b < 4; b++) if (w[8*b +: 8] > m) m = w[8*b +: 8];
    return m;
  endfunction

  function automatic logic [7:0] bmin(input logic [31:0] w, input logic [7:0] cur);
    logic [7:0] m;
    m = cur;
    for (int b = 0; b < 4; b++) if (w[8*b +: 8] < m) m = w[8*b +: 8];
    return m;
  endfunction

  function automatic vec_t mkv(input logic [15:0] base, input logic [15:0] count,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input logic [7:0] lat, input logic [7:0] hold, input logic early,
                               input logic [7:0] emax, input logic [7:0] emin);
    vec_t v;
    v.base = base; v.count = count;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.lat = lat; v.hold = hold; v.early = early; v.emax = emax; v.emin = emin;
    return v;
  endfunction

  // Memory: one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  // Accelerator: running max/min with a configurable done latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amax <= 8'h00; amin <= 8'hFF; busy <= 1'b0; dly <= 0; pend <= 32'h0; acc_done <= 1'b0;
    end else begin
      acc_done <= 1'b0;
      if (acc_clr) begin
        amax <= 8'h00; amin <= 8'hFF;
      end
      if (acc_start) begin
        busy <= 1'b1; dly <= lat_cfg; pend <= acc_data;
      end else if (busy && !stuck) begin
        if (dly == 0) begin
          busy <= 1'b0; acc_done <= 1'b1;
          amax <= bmax(pend, amax); amin <= bmin(pend, amin);
        end else begin
          dly <= dly - 1;
        end
      end
    end
  end
  assign acc_result = {16'h0000, amax, amin};

  // Protocol monitors on the accelerator side
  always @(posedge clk) begin
    if (rst_n && busy && acc_start) restart_viol <= restart_viol + 1;
    if (rst_n && busy && (acc_data !== pend)) data_viol <= data_viol + 1;
  end

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_total <= rd_total + 1;
      addr_log.push_back(mem_addr);
    end
    if (acc_start) start_total <= start_total + 1;
    if (acc_start && prev_start) start_wide <= start_wide + 1;
    prev_start <= acc_start;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic submit(input logic [15:0] base, input logic [15:0] count, input string tag);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, " cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_base = base; cmd_count = count;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int w, abase, rd0, st0, sw0, dv0, rv0;
    bit ok;
    exp_t got, e;
    logic [15:0] a;
    for (int i = 0; i < 4; i++) begin
      a = v.base + 16'(i);
      if (i < int'(v.count)) mem[a] = v.w[i];
    end
    lat_cfg = int'(v.lat);
    abase = addr_log.size(); rd0 = rd_total; st0 = start_total;
    sw0 = start_wide; dv0 = data_viol; rv0 = restart_viol;
    sb.push_back('{mx: v.emax, mn: v.emin, err: 1'b0});
    res_ready = v.early;
    submit(v.base, v.count, tag);
    w = 0;
    while (!res_valid && w < 3000) begin
      if (v.early && w == 3) begin
        cmd_valid = 1'b1; cmd_base = 16'h9999; cmd_count = 16'h0007;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      w++;
    end
    check({tag, " res_valid"}, res_valid, 1);
    if (v.count == 16'h0000) check({tag, " zero-count latency<=2"}, 32'(w <= 2), 1);
    got = {res_max, res_min, res_err};
    ok = 1'b1;
    for (int h = 0; h < int'(v.hold); h++) begin
      @(negedge clk);
      if (({res_max, res_min, res_err} !== got) || !res_valid || cmd_ready) ok = 1'b0;
    end
    if (v.hold != 8'd0) check({tag, " hold stable"}, 32'(ok), 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " valid dropped"}, res_valid, 0);
    check({tag, " cmd_ready after"}, cmd_ready, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " max"}, got.mx, e.mx);
      check({tag, " min"}, got.mn, e.mn);
      check({tag, " err"}, got.err, e.err);
    end
    check({tag, " reads"}, rd_total - rd0, v.count);
    check({tag, " starts"}, start_total - st0, v.count);
    check({tag, " start width"}, start_wide - sw0, 0);
    check({tag, " data stable"}, data_viol - dv0, 0);
    check({tag, " no restart"}, restart_viol - rv0, 0);
    ok = (addr_log.size() == abase + int'(v.count));
    for (int i = 0; i < int'(v.count) && ok; i++) begin
      a = v.base + 16'(i);
      if (addr_log[abase + i] !== a) ok = 1'b0;
    end
    check({tag, " addresses"}, 32'(ok), 1);
  endtask

  initial begin
    int w, seen;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_base = 16'h0; cmd_count = 16'h0;
    res_ready = 1'b0; stuck = 1'b0; lat_cfg = 1;
    vecs[0] = mkv(16'h0000, 16'd3, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0,
                  8'd2, 8'd0, 1'b0, 8'h0C, 8'h01);
    vecs[1] = mkv(16'h0100, 16'd0, 32'h0, 32'h0, 32'h0, 32'h0, 8'd1, 8'd0, 1'b0, 8'h00, 8'hFF);
    vecs[2] = mkv(16'h0200, 16'd2, 32'hFFFFFFFF, 32'h00000000, 32'h0, 32'h0,
                  8'd1, 8'd10, 1'b0, 8'hFF, 8'h00);
    vecs[3] = mkv(16'hFFFF, 16'd2, 32'h11223344, 32'h55667788, 32'h0, 32'h0,
                  8'd3, 8'd0, 1'b0, 8'h88, 8'h11);
    vecs[4] = mkv(16'h0300, 16'd4, 32'h40414243, 32'h3F3E3D3C, 32'h90919293, 32'h10111213,
                  8'd0, 8'd0, 1'b1, 8'h93, 8'h10);
    vecs[5] = mkv(16'h0400, 16'd1, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0, 8'd5, 8'd0, 1'b0, 8'hA5, 8'hA5);
    vecs[6] = mkv(16'h0010, 16'd1, 32'h05060708, 32'h0, 32'h0, 32'h0, 8'd1, 8'd0, 1'b0, 8'h08, 8'h05);

    repeat (3) @(negedge clk);
    check("reset cmd_ready", cmd_ready, 1);
    check("reset strobes", {mem_rd_en, acc_clr, acc_start, res_valid, res_err}, 0);
    check("reset data", {res_max, res_min, mem_addr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(vecs[i], $sformatf("v%0d", i));

    // Reset during WAIT_DONE of the second of four words
    lat_cfg = 8;
    for (int i = 0; i < 4; i++) mem[16'h0500 + 16'(i)] = 32'h0A0B0C0D + 32'(i);
    sb.push_back('{mx: 8'h0D, mn: 8'h0A, err: 1'b0});
    submit(16'h0500, 16'd4, "rst");
    w = 0; seen = 0;
    while (seen < 2 && w < 200) begin
      @(negedge clk);
      if (acc_start) seen++;
      w++;
    end
    check("rst second start", seen, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst cmd_ready", cmd_ready, 1);
    check("rst strobes", {mem_rd_en, acc_clr, acc_start, res_valid, res_err}, 0);
    check("rst data", {res_max, res_min, mem_addr}, 0);
    check("rst acc_data", acc_data, 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst no result", res_valid, 0);
    run_job(vecs[6], "v6");

`ifdef MAX_MIN_TIMEOUT_EN
    stuck = 1'b1; lat_cfg = 0;
    mem[16'h0600] = 32'h12345678; mem[16'h0601] = 32'h9ABCDEF0;
    submit(16'h0600, 16'd2, "wd");
    w = 0;
    while (!acc_start && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("wd start seen", acc_start, 1);
    w = 0;
    while (!res_valid && w < 1200) begin
      @(negedge clk);
      w++;
    end
    check("wd valid", res_valid, 1);
    check("wd cycles", w, 1025);
    check("wd err", res_err, 1);
    check("wd max", res_max, 8'h00);
    check("wd min", res_min, 8'hFF);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("wd cmd_ready after", cmd_ready, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
